// File: rtl/tlc_interval_timer_ctrl.sv
// -----------------------------------------------------------------------------
// tlc_interval_timer_ctrl
//   Timing and request controller for the traffic light FSM.
//   - Prescaler derives a one-cycle tick at the end of every second.
//   - sec_count counts whole seconds in the current phase (saturating) and is
//     restarted by the FSM's RstCount strobe.
//   - phase_done compares elapsed seconds with the limit of the current state;
//     it is the FSM's only transition condition.
//   - farmSensor is synchronised (2 FFs), debounced and latched into farm_req.
//
// Build option:
//   TLC_SIM_TICK_EN  defined   : prescaler period SIM_DIV, debounce length 2
//                    undefined : prescaler period CLK_HZ, debounce length DEB_CYC
//
// Ports:
//   Clk         in   1      system clock
//   Rst         in   1      synchronous reset, active-high
//   state       in   3      FSM state code S0=0 .. S5=5
//   RstCount    in   1      restart-interval strobe (priority over tick)
//   farmSensor  in   1      raw farm-road sensor, asynchronous
//   tick        out  1      one-cycle pulse at the end of each second
//   sec_count   out  SEC_W  seconds elapsed in the current phase
//   phase_done  out  1      current phase limit met (combinational)
//   farm_req    out  1      latched, debounced farm request
//   state_err   out  1      sticky illegal-state flag (state 6 or 7)
//
// Handshake: none; RstCount is a level sampled on every rising edge of Clk.
// -----------------------------------------------------------------------------
module tlc_interval_timer_ctrl #(
  parameter int CLK_HZ     = 50000000,
  parameter int SEC_W      = 5,
  parameter int T_ALLRED   = 1,
  parameter int T_HWY_MIN  = 30,
  parameter int T_YEL      = 3,
  parameter int T_FARM_MIN = 3,
  parameter int T_FARM_MAX = 15,
  parameter int DEB_CYC    = 1000,
  parameter int SIM_DIV    = 4
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [2:0]       state,
  input  logic             RstCount,
  input  logic             farmSensor,
  output logic             tick,
  output logic [SEC_W-1:0] sec_count,
  output logic             phase_done,
  output logic             farm_req,
  output logic             state_err
);

`ifdef TLC_SIM_TICK_EN
  localparam bit SIM_MODE = 1'b1;
`else
  localparam bit SIM_MODE = 1'b0;
`endif

  localparam int PERIOD  = SIM_MODE ? SIM_DIV : CLK_HZ;
  localparam int DEB_LEN = SIM_MODE ? 2 : DEB_CYC;
  localparam int PW      = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int DW      = (DEB_LEN > 1) ? $clog2(DEB_LEN) : 1;

  localparam logic [PW-1:0]    PRESC_LAST = PW'(PERIOD - 1);
  localparam logic [DW-1:0]    DEB_LAST   = DW'(DEB_LEN - 1);
  localparam logic [SEC_W-1:0] SEC_MAX    = '1;
  localparam logic [SEC_W-1:0] L_ALLRED   = SEC_W'(T_ALLRED);
  localparam logic [SEC_W-1:0] L_HWY_MIN  = SEC_W'(T_HWY_MIN);
  localparam logic [SEC_W-1:0] L_YEL      = SEC_W'(T_YEL);
  localparam logic [SEC_W-1:0] L_FARM_MIN = SEC_W'(T_FARM_MIN);
  localparam logic [SEC_W-1:0] L_FARM_MAX = SEC_W'(T_FARM_MAX);

  logic [PW-1:0] r_presc;
  logic          r_sync1;
  logic          r_sync2;
  logic [DW-1:0] r_deb_cnt;
  logic          r_farm_present;

  // Prescaler and seconds counter. RstCount restarts the whole interval so
  // the next tick lands exactly one full period after the restart edge.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_presc   <= '0;
      tick      <= 1'b0;
      sec_count <= '0;
    end else if (RstCount) begin
      r_presc   <= '0;
      tick      <= 1'b0;
      sec_count <= '0;
    end else if (r_presc == PRESC_LAST) begin
      r_presc <= '0;
      tick    <= 1'b1;
      if (sec_count != SEC_MAX) begin
        sec_count <= sec_count + 1'b1;
      end
    end else begin
      r_presc <= r_presc + 1'b1;
      tick    <= 1'b0;
    end
  end

  // Sensor path: two-flop synchroniser, then a run-length debounce. The
  // counter only advances while the synchronised level differs from the
  // accepted level, so any glitch back to the accepted level reloads it.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_sync1        <= 1'b0;
      r_sync2        <= 1'b0;
      r_deb_cnt      <= '0;
      r_farm_present <= 1'b0;
    end else begin
      r_sync1 <= farmSensor;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_farm_present) begin
        r_deb_cnt <= '0;
      end else if (r_deb_cnt == DEB_LAST) begin
        r_deb_cnt      <= '0;
        r_farm_present <= r_sync2;
      end else begin
        r_deb_cnt <= r_deb_cnt + 1'b1;
      end
    end
  end

  // Request latch (clear in S4 wins) and sticky illegal-state flag.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      farm_req  <= 1'b0;
      state_err <= 1'b0;
    end else begin
      if (state == 3'd4) begin
        farm_req <= 1'b0;
      end else if (r_farm_present) begin
        farm_req <= 1'b1;
      end
      if (state[2] && state[1]) begin
        state_err <= 1'b1;
      end
    end
  end

  // Phase limit compare; illegal codes report done so the FSM leaves them.
  always_comb begin
    phase_done = 1'b1;
    case (state)
      3'd0, 3'd3: phase_done = (sec_count >= L_ALLRED);
      3'd1:       phase_done = (sec_count >= L_HWY_MIN) && farm_req;
      3'd2, 3'd5: phase_done = (sec_count >= L_YEL);
      3'd4:       phase_done = ((sec_count >= L_FARM_MIN) && !r_farm_present)
                               || (sec_count >= L_FARM_MAX);
      default:    phase_done = 1'b1;
    endcase
  end

endmodule
